// File: rtl/qft3_result_serializer.sv
// Captures the QFT output vector a fixed pipeline latency after each launch.
// Streams the 8 captured complex amplitudes out, one per valid/ready beat.
module qft3_result_serializer #(
   parameter int DATA_W  = 4,
   parameter int LATENCY = 19
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     launch,
   input  logic [16*DATA_W-1:0]     f_flat,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [2:0]               m_idx,
   output logic signed [DATA_W-1:0] m_re,
   output logic signed [DATA_W-1:0] m_im,
   output logic                     m_last,
   output logic                     busy,
   output logic                     overrun
);

   localparam int AMP_W = 2*DATA_W;

   typedef enum logic {IDLE, STREAM} state_e;

   state_e                  stateQ;
   logic [LATENCY-1:0]      tagQ, tagD;
   logic [16*DATA_W-1:0]    snapQ;
   logic [2:0]              idxQ, idxInc;
   logic                    validQ, lastQ, busyQ, overrunQ;
   logic signed [DATA_W-1:0] reQ, imQ;
   logic                    cap, handshake, finalBeat;
   logic [AMP_W-1:0]        nextAmp, capAmp;

   // Launch tags ride alongside the QFT pipeline; the oldest stage marks the cycle f_flat is valid.
   always_comb begin
      tagD      = (tagQ << 1) | LATENCY'(launch);
      cap       = tagQ[LATENCY-1];
      handshake = validQ & m_ready;
      finalBeat = (idxQ == 3'd7);
      idxInc    = idxQ + 3'd1;
      nextAmp   = snapQ[int'(idxInc)*AMP_W +: AMP_W];
      capAmp    = f_flat[AMP_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= IDLE;
         tagQ     <= '0;
         snapQ    <= '0;
         idxQ     <= 3'd0;
         validQ   <= 1'b0;
         lastQ    <= 1'b0;
         busyQ    <= 1'b0;
         overrunQ <= 1'b0;
         reQ      <= '0;
         imQ      <= '0;
      end else begin
         tagQ <= tagD;
         case (stateQ)
            IDLE: begin
               if (cap) begin
                  snapQ  <= f_flat;
                  idxQ   <= 3'd0;
                  validQ <= 1'b1;
                  lastQ  <= 1'b0;
                  busyQ  <= 1'b1;
                  reQ    <= capAmp[DATA_W-1:0];
                  imQ    <= capAmp[AMP_W-1:DATA_W];
                  stateQ <= STREAM;
               end
            end
            STREAM: begin
               // A capture only fits if the final beat leaves in the same cycle.
               if (cap && !(handshake && finalBeat))
                  overrunQ <= 1'b1;
               if (handshake) begin
                  if (!finalBeat) begin
                     idxQ  <= idxInc;
                     lastQ <= (idxInc == 3'd7);
                     reQ   <= nextAmp[DATA_W-1:0];
                     imQ   <= nextAmp[AMP_W-1:DATA_W];
                  end else if (cap) begin
                     snapQ <= f_flat;
                     idxQ  <= 3'd0;
                     lastQ <= 1'b0;
                     reQ   <= capAmp[DATA_W-1:0];
                     imQ   <= capAmp[AMP_W-1:DATA_W];
                  end else begin
                     idxQ   <= 3'd0;
                     validQ <= 1'b0;
                     lastQ  <= 1'b0;
                     busyQ  <= 1'b0;
                     reQ    <= '0;
                     imQ    <= '0;
                     stateQ <= IDLE;
                  end
               end
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

   assign m_valid = validQ;
   assign m_idx   = idxQ;
   assign m_re    = reQ;
   assign m_im    = imQ;
   assign m_last  = lastQ;
   assign busy    = busyQ;
   assign overrun = overrunQ;

endmodule

// File: tb/tb_qft3_result_serializer.sv
// Self-checking bench: a delay-line stand-in for the QFT feeds f_flat, and a scoreboard
// of expected beats is filled at launch time and drained by a monitor on the falling edge.
module tb_qft3_result_serializer;

   localparam int DATA_W  = 4;
   localparam int LATENCY = 19;
   localparam int FW      = 16*DATA_W;

   logic clk = 1'b0;
   logic rst, launch, m_ready;
   logic [FW-1:0] f_flat, stimVec;
   logic m_valid, m_last, busy, overrun;
   logic [2:0] m_idx;
   logic signed [DATA_W-1:0] m_re, m_im;

   typedef struct packed {
      logic [2:0]        idx;
      logic              last;
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } beat_t;

   beat_t expQ[$];
   int    hsCycles[$];
   int    checks = 0;
   int    errors = 0;
   int    cycleCnt = 0;
   int    launchCyc;
   logic  toggleReady = 1'b0;
   logic  holdPending = 1'b0;
   beat_t holdBeat;
   logic [LATENCY-1:0][FW-1:0] stubPipe;

   qft3_result_serializer #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst), .launch(launch), .f_flat(f_flat),
      .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_re(m_re), .m_im(m_im),
      .m_last(m_last), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Upstream stand-in: the vector presented with launch appears on f_flat LATENCY edges later;
   // every other cycle carries random junk, so f_flat keeps changing after each capture.
   always @(posedge clk) begin
      stubPipe <= {stubPipe[LATENCY-2:0], stimVec};
      cycleCnt <= cycleCnt + 1;
   end
   assign f_flat = stubPipe[LATENCY-1];

   // Monitor: scores accepted beats and checks that stalled beats hold still.
   always @(negedge clk) begin
      beat_t obs, expB;
      obs = {m_idx, m_last, m_re, m_im};
      if (rst) begin
         holdPending = 1'b0;
      end else begin
         if (holdPending) begin
            checks++;
            assert (m_valid === 1'b1 && obs === holdBeat)
            else begin errors++; $error("FAIL hold observed=%h expected=%h", obs, holdBeat); end
         end
         holdPending = 1'b0;
         if (m_valid && m_ready) begin
            hsCycles.push_back(cycleCnt);
            checks++;
            assert (expQ.size() != 0)
            else begin errors++; $error("FAIL unexpected_beat observed=%h expected=none", obs); end
            if (expQ.size() != 0) begin
               expB = expQ.pop_front();
               checks++;
               assert (obs === expB)
               else begin errors++; $error("FAIL beat observed=%h expected=%h", obs, expB); end
            end
         end else if (m_valid) begin
            holdBeat    = obs;
            holdPending = 1'b1;
         end
      end
   end

   function automatic logic [FW-1:0] randVec();
      return {$urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      stimVec = randVec();
      if (toggleReady) m_ready = ~m_ready;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drives one launch and queues the first nPush beats the DUT is expected to emit for it.
   task automatic launchVec(input logic [FW-1:0] vec, input int nPush);
      beat_t b;
      launch    = 1'b1;
      stimVec   = vec;
      launchCyc = cycleCnt;
      for (int k = 0; k < nPush; k++) begin
         b.idx  = 3'(k);
         b.last = (k == 7);
         b.re   = vec[k*2*DATA_W +: DATA_W];
         b.im   = vec[k*2*DATA_W+DATA_W +: DATA_W];
         expQ.push_back(b);
      end
      tick();
      launch = 1'b0;
   endtask

   task automatic waitDrain(input int maxCycles);
      for (int i = 0; i < maxCycles && expQ.size() != 0; i++) tick();
      check("drain_timeout", 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      logic [FW-1:0] vA, vB;
      rst = 1'b1; launch = 1'b0; m_ready = 1'b1; stimVec = randVec();
      cycles(3);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_idx",   64'(m_idx),   64'd0);
      check("rst_re",    64'(m_re),    64'd0);
      check("rst_im",    64'(m_im),    64'd0);
      check("rst_last",  64'(m_last),  64'd0);
      check("rst_busy",  64'(busy),    64'd0);
      check("rst_ovr",   64'(overrun), 64'd0);
      rst = 1'b0;
      cycles(2);

      // Single launch with the ramp re=k-4, im=3-k.
      for (int k = 0; k < 8; k++) begin
         vA[k*2*DATA_W +: DATA_W]        = 4'(k - 4);
         vA[k*2*DATA_W+DATA_W +: DATA_W] = 4'(3 - k);
      end
      hsCycles.delete();
      launchVec(vA, 8);
      cycles(LATENCY + 1);
      check("t1_busy_mid", 64'(busy), 64'd1);
      waitDrain(40);
      check("t1_latency", 64'(hsCycles[0] - launchCyc), 64'(LATENCY + 1));
      check("t1_nbeats",  64'(hsCycles.size()), 64'd8);
      check("t1_span",    64'(hsCycles[7] - hsCycles[0]), 64'd7);
      check("t1_busy_end",  64'(busy),    64'd0);
      check("t1_valid_end", 64'(m_valid), 64'd0);
      check("t1_overrun",   64'(overrun), 64'd0);
      cycles(3);

      // |110> pattern in S1.2, downstream ready toggling every cycle.
      for (int k = 0; k < 8; k++) begin
         case (k % 4)
            0: begin vA[k*8 +: 4] = 4'sd4;  vA[k*8+4 +: 4] = 4'sd0;  end
            1: begin vA[k*8 +: 4] = 4'sd0;  vA[k*8+4 +: 4] = -4'sd4; end
            2: begin vA[k*8 +: 4] = -4'sd4; vA[k*8+4 +: 4] = 4'sd0;  end
            default: begin vA[k*8 +: 4] = 4'sd0; vA[k*8+4 +: 4] = 4'sd4; end
         endcase
      end
      hsCycles.delete();
      toggleReady = 1'b1;
      launchVec(vA, 8);
      waitDrain(60);
      toggleReady = 1'b0;
      m_ready = 1'b1;
      check("t2_nbeats", 64'(hsCycles.size()), 64'd8);
      check("t2_span",   64'(hsCycles[7] - hsCycles[0]), 64'd14);
      cycles(3);

      // Launches 8 apart: the second capture lands on the final handshake of the first.
      hsCycles.delete();
      vA = randVec(); vB = randVec();
      launchVec(vA, 8);
      cycles(7);
      launchVec(vB, 8);
      waitDrain(60);
      check("t3_nbeats",  64'(hsCycles.size()), 64'd16);
      check("t3_span",    64'(hsCycles[15] - hsCycles[0]), 64'd15);
      check("t3_overrun", 64'(overrun), 64'd0);
      cycles(3);

      // Launches 3 apart: the second capture is dropped and overrun sticks.
      hsCycles.delete();
      vA = randVec(); vB = randVec();
      launchVec(vA, 8);
      cycles(2);
      launchVec(vB, 0);
      waitDrain(60);
      cycles(5);
      check("t4_overrun", 64'(overrun), 64'd1);
      check("t4_nbeats",  64'(hsCycles.size()), 64'd8);
      cycles(10);
      check("t4_sticky",  64'(overrun), 64'd1);

      // Reset during beat 3 aborts the stream and discards a launch still in flight.
      hsCycles.delete();
      vA = randVec(); vB = randVec();
      launchVec(vA, 3);
      cycles(LATENCY - 2);
      launchVec(vB, 0);
      cycles(4);
      check("t5_idx_at_rst",   64'(m_idx),   64'd3);
      check("t5_valid_at_rst", 64'(m_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_valid", 64'(m_valid), 64'd0);
      check("t5_idx",   64'(m_idx),   64'd0);
      check("t5_re",    64'(m_re),    64'd0);
      check("t5_im",    64'(m_im),    64'd0);
      check("t5_last",  64'(m_last),  64'd0);
      check("t5_busy",  64'(busy),    64'd0);
      check("t5_ovr",   64'(overrun), 64'd0);
      cycles(40);
      check("t5_nbeats", 64'(hsCycles.size()), 64'd3);
      check("t5_left",   64'(expQ.size()),     64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
